// File: rtl/cache_ctrl_pkg.sv
// Shared state encoding and width helpers for the two-way cache controller.
package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWb,
        StFill,
        StFinish,
        StErr
    } state_e;

    // Number of bits needed to address n items (n >= 1).
    function automatic int unsigned log2_ceil(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/cache_victim_bits.sv
// Per-set victim-way bits: one flop per set, asynchronous reset, one read and one write port.
module cache_victim_bits
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SETS = 256,
    localparam int unsigned IDX_W   = log2_ceil(NUM_SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_val_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_val_i
);

    logic [NUM_SETS-1:0] bits_q, bits_d;

    always_comb begin
        bits_d = bits_q;
        if (wr_en_i) bits_d[wr_idx_i] = wr_val_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bits_q <= '0;
        else     bits_q <= bits_d;
    end

    assign rd_val_o = bits_q[rd_idx_i];

endmodule

// File: rtl/cache_ctrl_2way.sv
// Control FSM for a two-way set-associative cache: same-cycle hits, dirty victim
// writeback and a pipelined line fill whose installs overlap outstanding reads.
module cache_ctrl_2way
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 4,
    parameter int unsigned MEM_LAT   = 2,
    parameter int unsigned NUM_SETS  = 256,
    localparam int unsigned OFF_W    = log2_ceil(NUM_WORDS),
    localparam int unsigned IDX_W    = log2_ceil(NUM_SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_i,
    input  logic             wr_i,
    input  logic [IDX_W-1:0] index_i,
    input  logic             hit0_i,
    input  logic             hit1_i,
    input  logic             valid0_i,
    input  logic             valid1_i,
    input  logic             dirty0_i,
    input  logic             dirty1_i,
    input  logic             cache_err_i,
    input  logic             mem_stall_i,
    input  logic             mem_err_i,
    output logic             comp_o,
    output logic             cache_wr_o,
    output logic             way_sel_o,
    output logic [OFF_W-1:0] cache_off_o,
    output logic [OFF_W-1:0] mem_off_o,
    output logic             mem_victim_o,
    output logic             mem_rd_o,
    output logic             mem_wr_o,
    output logic             done_o,
    output logic             cache_hit_o,
    output logic             err_o,
    output logic             busy_o
);

    localparam logic [OFF_W-1:0] LastOff  = OFF_W'(NUM_WORDS - 1);
    localparam logic [OFF_W:0]   IssueEnd = (OFF_W + 1)'(NUM_WORDS);

    state_e             state_q, state_d;
    logic               victim_q, victim_d;
    logic [OFF_W-1:0]   wb_cnt_q, wb_cnt_d;
    logic [OFF_W-1:0]   inst_cnt_q, inst_cnt_d;
    logic [OFF_W:0]     issue_cnt_q, issue_cnt_d;
    logic [MEM_LAT-1:0] pend_q, pend_d;

    logic single_req, hit_w0, hit_w1, hit_way;
    logic vb_rd, vb_we, vb_val;
    logic miss_vic, miss_vic_valid, miss_vic_dirty;
    logic issue, ret;

    assign single_req     = rd_i ^ wr_i;
    assign hit_w0         = hit0_i & valid0_i;
    assign hit_w1         = hit1_i & valid1_i;
    assign hit_way        = hit_w1 & ~hit_w0;

    // Prefer an empty way; only consult the victim bit when both ways hold data.
    assign miss_vic       = !valid0_i ? 1'b0 : (!valid1_i ? 1'b1 : vb_rd);
    assign miss_vic_valid = miss_vic ? valid1_i : valid0_i;
    assign miss_vic_dirty = miss_vic ? dirty1_i : dirty0_i;

    assign issue = (state_q == StFill) && (issue_cnt_q < IssueEnd) && !mem_stall_i;
    assign ret   = (state_q == StFill) && pend_q[MEM_LAT-1];

    cache_victim_bits #(
        .NUM_SETS (NUM_SETS)
    ) u_victim (
        .clk      (clk),
        .rst      (rst),
        .rd_idx_i (index_i),
        .rd_val_o (vb_rd),
        .wr_en_i  (vb_we),
        .wr_idx_i (index_i),
        .wr_val_i (vb_val)
    );

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        wb_cnt_d     = '0;
        issue_cnt_d  = '0;
        inst_cnt_d   = '0;
        pend_d       = '0;
        vb_we        = 1'b0;
        vb_val       = 1'b0;
        comp_o       = 1'b0;
        cache_wr_o   = 1'b0;
        way_sel_o    = 1'b0;
        cache_off_o  = '0;
        mem_off_o    = '0;
        mem_victim_o = 1'b0;
        mem_rd_o     = 1'b0;
        mem_wr_o     = 1'b0;
        done_o       = 1'b0;
        cache_hit_o  = 1'b0;
        err_o        = 1'b0;
        busy_o       = 1'b0;

        // Outputs stay quiet for the whole reset pulse, even if requests are present.
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    if (single_req) begin
                        comp_o     = 1'b1;
                        cache_wr_o = wr_i;
                        way_sel_o  = hit_way;
                    end
                    if ((rd_i && wr_i) || (single_req && cache_err_i)) begin
                        done_o = 1'b1;
                        err_o  = 1'b1;
                    end else if (single_req) begin
                        if (hit_w0 || hit_w1) begin
                            done_o      = 1'b1;
                            cache_hit_o = 1'b1;
                            vb_we       = 1'b1;
                            vb_val      = ~hit_way;
                        end else begin
                            victim_d = miss_vic;
                            if (miss_vic_valid && miss_vic_dirty) state_d = StWb;
                            else if (miss_vic_dirty)              state_d = StErr;
                            else                                  state_d = StFill;
                        end
                    end
                end

                StWb: begin
                    busy_o       = 1'b1;
                    mem_wr_o     = !mem_stall_i;
                    mem_victim_o = 1'b1;
                    way_sel_o    = victim_q;
                    cache_off_o  = wb_cnt_q;
                    mem_off_o    = wb_cnt_q;
                    wb_cnt_d     = wb_cnt_q;
                    if (mem_err_i) begin
                        state_d = StErr;
                    end else if (!mem_stall_i) begin
                        if (wb_cnt_q == LastOff) begin
                            wb_cnt_d = '0;
                            state_d  = StFill;
                        end else begin
                            wb_cnt_d = wb_cnt_q + OFF_W'(1);
                        end
                    end
                end

                StFill: begin
                    busy_o      = 1'b1;
                    way_sel_o   = victim_q;
                    mem_rd_o    = issue;
                    mem_off_o   = issue_cnt_q[OFF_W-1:0];
                    issue_cnt_d = issue ? issue_cnt_q + (OFF_W + 1)'(1) : issue_cnt_q;
                    inst_cnt_d  = inst_cnt_q;
                    // Each slot marks one read in flight; the oldest emerges MEM_LAT cycles later.
                    pend_d      = (pend_q << 1) | MEM_LAT'(issue);
                    if (ret) begin
                        cache_wr_o  = 1'b1;
                        cache_off_o = inst_cnt_q;
                        inst_cnt_d  = inst_cnt_q + OFF_W'(1);
                    end
                    if (mem_err_i) begin
                        state_d = StErr;
                    end else if (ret && inst_cnt_q == LastOff) begin
                        state_d = StFinish;
                    end
                end

                StFinish: begin
                    busy_o     = 1'b1;
                    comp_o     = 1'b1;
                    cache_wr_o = wr_i;
                    way_sel_o  = victim_q;
                    done_o     = 1'b1;
                    err_o      = cache_err_i;
                    vb_we      = 1'b1;
                    vb_val     = ~victim_q;
                    state_d    = StIdle;
                end

                StErr: begin
                    busy_o  = 1'b1;
                    done_o  = 1'b1;
                    err_o   = 1'b1;
                    state_d = StIdle;
                end

                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            victim_q    <= 1'b0;
            wb_cnt_q    <= '0;
            issue_cnt_q <= '0;
            inst_cnt_q  <= '0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            victim_q    <= victim_d;
            wb_cnt_q    <= wb_cnt_d;
            issue_cnt_q <= issue_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
            pend_q      <= pend_d;
        end
    end

`ifndef SYNTHESIS
    a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
        !(mem_rd_o && mem_wr_o));
    a_done_quiet: assert property (@(posedge clk) disable iff (rst)
        done_o |-> (state_q != StWb && state_q != StFill));
`endif

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Randomized and directed bench for cache_ctrl_2way against an event-schedule reference model.
module tb_cache_ctrl_2way;

    localparam int NW  = 4;
    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rd, wr, hit0, hit1, valid0, valid1, dirty0, dirty1;
    logic       cache_err, mem_stall, mem_err;
    logic [7:0] index;
    logic       comp, cache_wr, way_sel, mem_victim, mem_rd, mem_wr;
    logic       done, cache_hit, err, busy;
    logic [1:0] cache_off, mem_off;

    int checks = 0;
    int errors = 0;
    bit vbits [256];

    always #5 clk = ~clk;

    cache_ctrl_2way #(
        .NUM_WORDS (NW),
        .MEM_LAT   (LAT),
        .NUM_SETS  (256)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_i         (rd),
        .wr_i         (wr),
        .index_i      (index),
        .hit0_i       (hit0),
        .hit1_i       (hit1),
        .valid0_i     (valid0),
        .valid1_i     (valid1),
        .dirty0_i     (dirty0),
        .dirty1_i     (dirty1),
        .cache_err_i  (cache_err),
        .mem_stall_i  (mem_stall),
        .mem_err_i    (mem_err),
        .comp_o       (comp),
        .cache_wr_o   (cache_wr),
        .way_sel_o    (way_sel),
        .cache_off_o  (cache_off),
        .mem_off_o    (mem_off),
        .mem_victim_o (mem_victim),
        .mem_rd_o     (mem_rd),
        .mem_wr_o     (mem_wr),
        .done_o       (done),
        .cache_hit_o  (cache_hit),
        .err_o        (err),
        .busy_o       (busy)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        {rd, wr, hit0, hit1, valid0, valid1, dirty0, dirty1} = '0;
        {cache_err, mem_stall, mem_err} = '0;
        index = '0;
    endtask

    task automatic set_req(input bit r, input bit w, input int idx, input bit h0, input bit h1,
                           input bit v0, input bit v1, input bit d0, input bit d1);
        rd = r; wr = w; index = 8'(idx);
        hit0 = h0; hit1 = h1; valid0 = v0; valid1 = v1; dirty0 = d0; dirty1 = d1;
    endtask

    task automatic test_reset();
        idle_inputs();
        set_req(1, 0, 1, 1, 0, 1, 0, 0, 0);
        #1;
        checks++;
        if ({comp, cache_wr, way_sel, cache_off, mem_off, mem_victim, mem_rd, mem_wr, done,
             cache_hit, err, busy} !== 15'd0) begin
            errors++; $display("FAIL reset_outputs: got nonzero outputs, want all 0");
        end
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) vbits[i] = 1'b0;
        next_cycle(); sample();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_read_hit();
        next_cycle(); set_req(1, 0, 5, 0, 1, 1, 1, 0, 0); sample();
        checks++;
        if ({done, cache_hit, way_sel, comp, err, busy} !== 6'b111100) begin
            errors++;
            $display("FAIL read_hit: done=%b hit=%b way=%b comp=%b err=%b busy=%b want 111100",
                     done, cache_hit, way_sel, comp, err, busy);
        end
        vbits[5] = 1'b0;
        next_cycle(); idle_inputs(); sample();
    endtask

    task automatic test_clean_miss();
        bit e_rd, e_cwr;
        next_cycle(); set_req(1, 0, 3, 0, 0, 1, 1, 0, 0); sample();
        checks++;
        if (done !== 1'b0 || comp !== 1'b1) begin
            errors++; $display("FAIL clean_c0: done=%b comp=%b want 0 1", done, comp);
        end
        for (int c = 1; c <= 7; c++) begin
            next_cycle(); sample();
            e_rd  = (c >= 1 && c <= 4);
            e_cwr = (c >= 3 && c <= 6);
            checks++;
            if (mem_rd !== e_rd || cache_wr !== e_cwr || done !== (c == 7)) begin
                errors++;
                $display("FAIL clean_c%0d: rd=%b cwr=%b done=%b want %b %b %b",
                         c, mem_rd, cache_wr, done, e_rd, e_cwr, c == 7);
            end
            if (e_rd) begin
                checks++;
                if (mem_off !== 2'(c - 1)) begin
                    errors++; $display("FAIL clean_moff c%0d: got %0d want %0d", c, mem_off, c - 1);
                end
            end
            if (e_cwr) begin
                checks++;
                if (cache_off !== 2'(c - 3) || way_sel !== 1'b0) begin
                    errors++;
                    $display("FAIL clean_install c%0d: off=%0d way=%b want %0d 0",
                             c, cache_off, way_sel, c - 3);
                end
            end
        end
        checks++;
        if (cache_hit !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL clean_done_flags: hit=%b err=%b want 0 0", cache_hit, err);
        end
        vbits[3] = 1'b1;
        next_cycle(); idle_inputs(); sample();
    endtask

    task automatic test_dirty_miss();
        bit e_mwr, e_mrd, e_cwr;
        next_cycle(); set_req(0, 1, 3, 0, 0, 1, 1, 0, 1); sample();
        for (int c = 1; c <= 11; c++) begin
            next_cycle(); sample();
            e_mwr = (c >= 1 && c <= 4);
            e_mrd = (c >= 5 && c <= 8);
            e_cwr = (c >= 7 && c <= 11);
            checks++;
            if (mem_wr !== e_mwr || mem_rd !== e_mrd || cache_wr !== e_cwr || done !== (c == 11))
            begin
                errors++;
                $display("FAIL dirty_c%0d: mwr=%b mrd=%b cwr=%b done=%b want %b %b %b %b",
                         c, mem_wr, mem_rd, cache_wr, done, e_mwr, e_mrd, e_cwr, c == 11);
            end
            if (e_mwr) begin
                checks++;
                if (mem_victim !== 1'b1 || mem_off !== 2'(c - 1) || way_sel !== 1'b1) begin
                    errors++;
                    $display("FAIL dirty_wb c%0d: vic=%b off=%0d way=%b want 1 %0d 1",
                             c, mem_victim, mem_off, way_sel, c - 1);
                end
            end
            if (e_cwr && c < 11) begin
                checks++;
                if (cache_off !== 2'(c - 7) || way_sel !== 1'b1) begin
                    errors++;
                    $display("FAIL dirty_install c%0d: off=%0d way=%b want %0d 1",
                             c, cache_off, way_sel, c - 7);
                end
            end
        end
        checks++;
        if (comp !== 1'b1 || cache_hit !== 1'b0) begin
            errors++; $display("FAIL dirty_finish: comp=%b hit=%b want 1 0", comp, cache_hit);
        end
        vbits[3] = 1'b0;
        next_cycle(); idle_inputs(); sample();
    endtask

    task automatic test_stall();
        next_cycle(); set_req(1, 0, 9, 0, 0, 1, 1, 0, 0); sample();
        for (int c = 1; c <= 9; c++) begin
            next_cycle(); mem_stall = (c == 2 || c == 3); sample();
            if (c >= 2 && c <= 4) begin
                checks++;
                if (mem_off !== 2'd1 || mem_rd !== (c == 4)) begin
                    errors++;
                    $display("FAIL stall_c%0d: off=%0d rd=%b want 1 %b", c, mem_off, mem_rd, c == 4);
                end
            end
            if (c >= 8) begin
                checks++;
                if (done !== (c == 9)) begin
                    errors++; $display("FAIL stall_done c%0d: got %b want %b", c, done, c == 9);
                end
            end
        end
        vbits[9] = 1'b1;
        next_cycle(); idle_inputs(); sample();
    endtask

    task automatic test_mem_err();
        next_cycle(); set_req(1, 0, 10, 0, 0, 1, 1, 1, 0); sample();
        next_cycle(); sample();
        checks++;
        if (mem_wr !== 1'b1) begin
            errors++; $display("FAIL merr_wb: mem_wr=%b want 1", mem_wr);
        end
        next_cycle(); mem_err = 1'b1; sample();
        next_cycle(); mem_err = 1'b0; sample();
        checks++;
        if ({done, err, busy} !== 3'b111) begin
            errors++; $display("FAIL merr_c3: done=%b err=%b busy=%b want 111", done, err, busy);
        end
        next_cycle(); idle_inputs(); sample();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL merr_c4: busy=%b done=%b want 0 0", busy, done);
        end
        for (int c = 5; c <= 8; c++) begin
            next_cycle(); sample();
            checks++;
            if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
                errors++; $display("FAIL merr_quiet c%0d: rd=%b wr=%b want 0 0", c, mem_rd, mem_wr);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        bit seen;
        next_cycle(); set_req(1, 0, 9, 0, 0, 1, 1, 0, 0); sample();
        for (int c = 1; c <= 4; c++) begin next_cycle(); sample(); end
        next_cycle(); rst = 1'b1; #1;
        checks++;
        if ({comp, cache_wr, way_sel, cache_off, mem_off, mem_victim, mem_rd, mem_wr, done,
             cache_hit, err, busy} !== 15'd0) begin
            errors++; $display("FAIL rst_mid_fill: outputs nonzero under reset, want all 0");
        end
        for (int i = 0; i < 256; i++) vbits[i] = 1'b0;
        idle_inputs();
        next_cycle(); rst = 1'b0;
        next_cycle(); set_req(1, 0, 9, 0, 0, 1, 1, 0, 0); sample();
        next_cycle(); sample();
        checks++;
        if (mem_rd !== 1'b1 || mem_off !== 2'd0) begin
            errors++; $display("FAIL rst_restart_c1: rd=%b off=%0d want 1 0", mem_rd, mem_off);
        end
        next_cycle(); sample();
        next_cycle(); sample();
        checks++;
        if (cache_wr !== 1'b1 || way_sel !== 1'b0 || cache_off !== 2'd0) begin
            errors++;
            $display("FAIL rst_restart_c3: cwr=%b way=%b off=%0d want 1 0 0",
                     cache_wr, way_sel, cache_off);
        end
        seen = 1'b0;
        for (int c = 4; c <= 20 && !seen; c++) begin
            next_cycle(); sample();
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL rst_restart_done: done=0 within bound, want 1");
        end
        vbits[9] = 1'b1;
        next_cycle(); idle_inputs(); sample();
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int idx, kind, fin, tt, vic;
            bit r, w, h0, h1, v0, v1, d0, d1, ce, hw, vv, vd;
            bit stl [128];
            bit e_mrd [128];
            bit e_mwr [128];
            bit e_cwr [128];
            int e_moff [128];
            int e_coff [128];
            idx  = $urandom_range(0, 7);
            kind = $urandom_range(0, 11);
            v0 = ($urandom_range(0, 3) != 0); v1 = ($urandom_range(0, 3) != 0);
            h0 = ($urandom_range(0, 2) == 0); h1 = ($urandom_range(0, 2) == 0);
            d0 = 1'($urandom_range(0, 1));    d1 = 1'($urandom_range(0, 1));
            ce = (kind == 0);
            if (kind == 1) begin r = 1; w = 1; end
            else begin r = 1'($urandom_range(0, 1)); w = !r; end
            for (int c = 0; c < 128; c++) begin
                stl[c] = (c > 0 && c < 40) ? ($urandom_range(0, 3) == 0) : 1'b0;
                e_mrd[c] = 0; e_mwr[c] = 0; e_cwr[c] = 0; e_moff[c] = 0; e_coff[c] = 0;
            end
            next_cycle(); set_req(r, w, idx, h0, h1, v0, v1, d0, d1); cache_err = ce; sample();
            if ((r && w) || ce) begin
                checks++;
                if ({done, err, cache_hit, busy} !== 4'b1100) begin
                    errors++;
                    $display("FAIL rnd%0d_reqerr: done=%b err=%b hit=%b busy=%b want 1100",
                             t, done, err, cache_hit, busy);
                end
            end else if ((h0 && v0) || (h1 && v1)) begin
                hw = !(h0 && v0);
                checks++;
                if ({done, cache_hit, err, way_sel, comp, cache_wr} !== {3'b110, hw, 1'b1, w}) begin
                    errors++;
                    $display("FAIL rnd%0d_hit: done=%b hit=%b err=%b way=%b comp=%b cwr=%b want way %b",
                             t, done, cache_hit, err, way_sel, comp, cache_wr, hw);
                end
                vbits[idx] = !hw;
            end else begin
                vic = !v0 ? 0 : (!v1 ? 1 : int'(vbits[idx]));
                vv  = vic ? v1 : v0;
                vd  = vic ? d1 : d0;
                checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    errors++; $display("FAIL rnd%0d_miss_c0: done=%b busy=%b want 0 0", t, done, busy);
                end
                if (vd && !vv) begin
                    next_cycle(); sample();
                    checks++;
                    if ({done, err} !== 2'b11) begin
                        errors++; $display("FAIL rnd%0d_badvic: done=%b err=%b want 11", t, done, err);
                    end
                end else begin
                    tt = 1;
                    if (vd) begin
                        for (int k = 0; k < NW; k++) begin
                            while (stl[tt]) tt++;
                            e_mwr[tt] = 1; e_moff[tt] = k; e_coff[tt] = k; tt++;
                        end
                    end
                    fin = 0;
                    for (int k = 0; k < NW; k++) begin
                        while (stl[tt]) tt++;
                        e_mrd[tt] = 1; e_moff[tt] = k;
                        e_cwr[tt + LAT] = 1; e_coff[tt + LAT] = k;
                        fin = tt + LAT + 1; tt++;
                    end
                    e_cwr[fin] = w;
                    for (int c = 1; c <= fin; c++) begin
                        next_cycle(); mem_stall = stl[c]; sample();
                        checks++;
                        if (mem_rd !== e_mrd[c] || mem_wr !== e_mwr[c] || cache_wr !== e_cwr[c] ||
                            done !== (c == fin)) begin
                            errors++;
                            $display("FAIL rnd%0d_c%0d: rd=%b wr=%b cwr=%b done=%b want %b %b %b %b",
                                     t, c, mem_rd, mem_wr, cache_wr, done,
                                     e_mrd[c], e_mwr[c], e_cwr[c], c == fin);
                        end
                        if (e_mrd[c] || e_mwr[c]) begin
                            checks++;
                            if (mem_off !== 2'(e_moff[c]) || mem_victim !== e_mwr[c]) begin
                                errors++;
                                $display("FAIL rnd%0d_moff c%0d: off=%0d vic=%b want %0d %b",
                                         t, c, mem_off, mem_victim, e_moff[c], e_mwr[c]);
                            end
                        end
                        if ((e_cwr[c] || e_mwr[c]) && c != fin) begin
                            checks++;
                            if (cache_off !== 2'(e_coff[c]) || way_sel !== 1'(vic)) begin
                                errors++;
                                $display("FAIL rnd%0d_coff c%0d: off=%0d way=%b want %0d %0d",
                                         t, c, cache_off, way_sel, e_coff[c], vic);
                            end
                        end
                        if (c == fin) begin
                            checks++;
                            if ({comp, cache_hit, err, way_sel} !== {3'b100, 1'(vic)}) begin
                                errors++;
                                $display("FAIL rnd%0d_fin: comp=%b hit=%b err=%b way=%b want way %0d",
                                         t, comp, cache_hit, err, way_sel, vic);
                            end
                        end
                    end
                    mem_stall = 1'b0;
                    vbits[idx] = !1'(vic);
                end
            end
            next_cycle(); idle_inputs(); sample();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++; $display("FAIL rnd%0d_idle: busy=%b done=%b want 0 0", t, busy, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_clean_miss();
        test_dirty_miss();
        test_stall();
        test_mem_err();
        test_reset_mid_fill();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_2way.md
Name: cache_ctrl_2way

Overview:
Control FSM for a two-way set-associative cache with multi-word lines in front of the banked main memory.
It resolves hits in the request cycle and picks a victim way using a per-set victim bit.
On a miss it writes back a dirty victim line word by word, then fills the line. Fill reads are pipelined and overlap the installs of returning words.
Data and tag datapaths stay outside; this block drives only control.

Parameters:
NUM_WORDS, 4, words per line (power of 2, >=2); OFF_W = log2(NUM_WORDS)
MEM_LAT, 2, cycles from mem_rd issue to data valid at the cache input (>=1)
NUM_SETS, 256, sets per way; IDX_W = log2(NUM_SETS)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
rd  in  1  read request; held stable with address and data until done
wr  in  1  write request; same hold rule as rd
index  in  IDX_W  set index of the request
hit0, hit1  in  1  tag match, way 0 / way 1 (valid only while comp=1)
valid0, valid1  in  1  line valid bit, per way
dirty0, dirty1  in  1  line dirty bit, per way
cache_err  in  1  cache array error
mem_stall  in  1  target memory bank busy; do not issue this cycle
mem_err  in  1  memory error
comp  out  1  cache compare mode (tag match / write-with-dirty)
cache_wr  out  1  cache array write enable
way_sel  out  1  way addressed by the cache
cache_off  out  OFF_W  word offset for cache access during WB/fill
mem_off  out  OFF_W  word offset for the memory request
mem_victim  out  1  1: memory address uses the victim tag (writeback)
mem_rd, mem_wr  out  1  memory request strobes
done  out  1  one-cycle completion pulse
cache_hit  out  1  qualifies done: request hit
err  out  1  qualifies done: error
busy  out  1  1 in every state except IDLE

Behaviour:
- Reset (async): state IDLE; all counters 0; every victim bit 0; all outputs 0.
- States: IDLE, WB, FILL, FINISH, ERR.
- IDLE, rd^wr:
  - comp=1, cache_wr=wr.
  - Hit when (hit0&valid0)|(hit1&valid1). way_sel is the hitting way (way0 wins if both).
  - On hit with no cache_err: done=1 and cache_hit=1 in the same cycle. Victim bit[index] is set to the other way. Stay IDLE.
- Miss, victim choice: first invalid way (way0 first); if both valid, victim bit[index]. Victim way is latched.
- Miss, next state: WB if victim valid & dirty; ERR if victim dirty & !valid; else FILL.
- IDLE, rd&wr, or cache_err in IDLE: done=1, err=1 same cycle, no state change.
- WB:
  - mem_wr=1, mem_victim=1, comp=0, cache_wr=0, way_sel=victim, cache_off=mem_off=wb_cnt.
  - mem_stall holds wb_cnt and suppresses mem_wr.
  - After word NUM_WORDS-1 is accepted, go to FILL.
- FILL, issue side:
  - While issue_cnt<NUM_WORDS and !mem_stall: mem_rd=1, mem_off=issue_cnt, then issue_cnt++.
- FILL, return tracking:
  - A MEM_LAT-deep shift register tracks outstanding reads.
  - When its output is 1: cache_wr=1, comp=0, way_sel=victim, cache_off=inst_cnt, then inst_cnt++.
  - The pipeline advances regardless of mem_stall.
- FILL exit: after install NUM_WORDS-1, go to FINISH.
- FINISH: comp=1, cache_wr=wr, way_sel=victim, done=1, cache_hit=0; victim bit[index]=~victim; go to IDLE. cache_err here gives err=1 as well.
- mem_err in WB or FILL: go to ERR; outstanding returns are discarded.
- ERR: done=1, err=1 for one cycle, then IDLE.
- Clean miss latency: done at cycle NUM_WORDS+MEM_LAT+1 after the request cycle, with no stalls. A dirty miss adds NUM_WORDS.
- Each mem_stall cycle during issue adds one cycle.
- Counters: wrap-free (reset to 0 on entry to WB/FILL). Shift register cleared on entry to FILL and on ERR.
- Outputs are combinational from state, counters and inputs. No output toggles while rst=1.

Decomposition:
- cache_ctrl_pkg: state encodings, and helpers for OFF_W/IDX_W derivation.
- Sub-module cache_victim_bits: NUM_SETS x 1 register array with async reset, read port (index) and write port (wr_en, index, value).

Test Plan:
- Read hit way1, index 5: rd=1, hit1=valid1=1 -> same cycle done=1, cache_hit=1, way_sel=1; victim bit[5]=0 afterwards.
- Clean read miss, both ways valid, victim bit[3]=0, MEM_LAT=2:
  - mem_rd at c1..c4 with mem_off 0..3.
  - cache_wr at c3..c6 with cache_off 0..3, way_sel=0.
  - done=1, cache_hit=0 at c7; victim bit[3]=1.
- Write miss, dirty valid victim way1:
  - mem_wr with mem_victim=1 at c1..c4.
  - mem_rd at c5..c8; installs at c7..c10.
  - c11: comp=1, cache_wr=1, done=1.
- Clean miss with mem_stall=1 at c2..c3: mem_off stays 1 through c4; done at c9.
- mem_err during WB at c2 -> c3: done=1, err=1; c4: busy=0, IDLE; no further mem_rd.
- rst pulsed mid-FILL (c5) -> outputs 0 immediately; next rd miss restarts at mem_off 0 with victim way0.
